counter_sched: RTL and testbench

Round-robin scheduler that shares one loadable up-counter (3-bit by default, terminal count at all-ones) among NREQ requesters. Each requester presents a start value. The scheduler grants one requester at a time, loads the counter with that value, enables counting until terminal count, then pulses a per-requester done. It sits between client blocks and the counter datapath and is the only driver of the counter's load and enable inputs.

---
 rtl/counter_sched.sv | 177 +++++++++++++++++
 tb/tb_counter_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one loadable up-counter among NREQ requesters.
// Optional watchdog abort is compiled in with `define COUNTER_SCHED_WDOG_EN.
module counter_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] load_val,
  input  logic [CW-1:0]    count_out,
  input  logic             tc,
  output logic             ld_enb,
  output logic [CW-1:0]    ld_data,
  output logic             cnt_en,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic             err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
`ifdef COUNTER_SCHED_WDOG_EN
    StDone,
    StAbort
`else
    StDone
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d, next_owner, cand;
  logic [CW-1:0]   val_q, val_d;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  logic            ld_enb_d, cnt_en_d, busy_d;
  logic [CW-1:0]   ld_data_d;
  logic [NREQ-1:0] grant_d, done_d;

  // Count_out is a monitor-only input; the sequence is driven purely by tc.
  logic            unused_count;
  assign unused_count = ^count_out;

`ifdef COUNTER_SCHED_WDOG_EN
  localparam logic [CW:0] WdogLast = {1'b1, {CW{1'b0}}};
  logic [CW:0] run_cnt_q, run_cnt_d;
  logic        err_d;
`else
  assign err = 1'b0;
`endif

  // First requesting index at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign next_owner = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    val_d   = val_q;
`ifdef COUNTER_SCHED_WDOG_EN
    run_cnt_d = run_cnt_q;
    if (state_q == StLoad) begin
      run_cnt_d = '0;
    end else if (state_q == StRun) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          val_d   = load_val[32'(pick_idx)*CW +: CW];
          state_d = StLoad;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        if (tc) begin
          state_d = StDone;
`ifdef COUNTER_SCHED_WDOG_EN
        end else if (run_cnt_q == WdogLast) begin
          state_d = StAbort;
`endif
        end
      end
      StDone: begin
        ptr_d   = next_owner;
        state_d = StIdle;
      end
`ifdef COUNTER_SCHED_WDOG_EN
      StAbort: begin
        ptr_d   = next_owner;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    ld_enb_d  = (state_d == StLoad);
    ld_data_d = (state_d == StLoad) ? val_d : '0;
    cnt_en_d  = (state_d == StRun);
    busy_d    = (state_d != StIdle);
    grant_d   = '0;
    done_d    = '0;
    if (state_d == StLoad || state_d == StRun || state_d == StDone) begin
      grant_d[owner_d] = 1'b1;
    end
    if (state_d == StDone) begin
      done_d[owner_d] = 1'b1;
    end
`ifdef COUNTER_SCHED_WDOG_EN
    err_d = (state_d == StAbort);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      val_q   <= '0;
      ld_enb  <= 1'b0;
      ld_data <= '0;
      cnt_en  <= 1'b0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      val_q   <= val_d;
      ld_enb  <= ld_enb_d;
      ld_data <= ld_data_d;
      cnt_en  <= cnt_en_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

`ifdef COUNTER_SCHED_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
      err       <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      err       <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched with a behavioural counter model.
// Watchdog scenario runs only when COUNTER_SCHED_WDOG_EN is defined.
module tb_counter_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] load_val;
  logic [2:0]  count_out = '0;
  logic        tc;
  logic        tc_kill;
  logic        ld_enb, cnt_en, busy, err;
  logic [2:0]  ld_data;
  logic [3:0]  grant, done;

  typedef struct { logic [3:0] vec; int val; } gexp_t;
  typedef struct { logic [3:0] vec; int cyc; } dexp_t;

  gexp_t q_grant[$];
  dexp_t q_done[$];
  dexp_t q_err[$];
  gexp_t g;
  dexp_t d;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, ld_seen = 0, done_seen = 0, err_seen = 0;
  int last_done_cyc = -1;
  int ptr_m = 0;
  logic b2b = 1'b0;

  counter_sched #(.NREQ(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .load_val(load_val), .count_out(count_out),
    .tc(tc), .ld_enb(ld_enb), .ld_data(ld_data), .cnt_en(cnt_en), .grant(grant),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter datapath: loads on ld_enb, counts on cnt_en, holds at all-ones.
  always @(posedge clk) begin
    if (ld_enb) count_out <= ld_data;
    else if (cnt_en && count_out != 3'd7) count_out <= count_out + 3'd1;
  end
  assign tc = (count_out == 3'd7) && !tc_kill;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic set_vals(input int v0, input int v1, input int v2, input int v3);
    load_val = {3'(v3), 3'(v2), 3'(v1), 3'(v0)};
  endtask

  task automatic expect_grant(input logic [3:0] r);
    int o;
    gexp_t e;
    o = rr_pick(r, ptr_m);
    e.vec = 4'(1 << o);
    e.val = int'(load_val[o*3 +: 3]);
    q_grant.push_back(e);
    ptr_m = (o + 1) % 4;
  endtask

  task automatic wait_ld(input int target);
    int n = 0;
    while (ld_seen < target && n < 50) begin @(negedge clk); #1; n++; end
    if (ld_seen < target) check_eq("timeout_ld", ld_seen, target);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 100) begin @(negedge clk); #1; n++; end
    if (done_seen < target) check_eq("timeout_done", done_seen, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_ld_enb"}, ld_enb, 0);
    check_eq({tag, "_ld_data"}, ld_data, 0);
    check_eq({tag, "_cnt_en"}, cnt_en, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  task automatic single_run(input logic [3:0] r);
    expect_grant(r);
    req = r;
    wait_ld(ld_seen + 1);
    req = '0;
    wait_done(done_seen + 1);
  endtask

  // Monitor: pops expectations as the DUT produces load strobes, dones and aborts.
  always @(negedge clk) begin
    if (!rst) begin
      if (ld_enb) begin
        if (q_grant.size() == 0) begin
          check_eq("unexpected_ld", 1, 0);
        end else begin
          g = q_grant.pop_front();
          check_eq("grant", grant, g.vec);
          check_eq("ld_data", ld_data, g.val);
          if (b2b) check_eq("b2b_gap", cyc - last_done_cyc, 2);
          d.vec = g.vec;
          if (tc_kill) begin
            d.cyc = cyc + 10;
            q_err.push_back(d);
          end else begin
            d.cyc = cyc + 2 + (7 - g.val);
            q_done.push_back(d);
          end
        end
        ld_seen++;
      end
      if (done != 0) begin
        if (q_done.size() == 0) begin
          check_eq("unexpected_done", done, 0);
        end else begin
          d = q_done.pop_front();
          check_eq("done_vec", done, d.vec);
          check_eq("done_cycle", cyc, d.cyc);
          check_eq("cnt_en_at_done", cnt_en, 0);
          check_eq("count_at_done", count_out, 7);
        end
        done_seen++;
        last_done_cyc = cyc;
      end
      if (err) begin
        if (q_err.size() == 0) begin
          check_eq("unexpected_err", err, 0);
        end else begin
          d = q_err.pop_front();
          check_eq("err_cycle", cyc, d.cyc);
          check_eq("err_grant", grant, 0);
          check_eq("err_cnt_en", cnt_en, 0);
        end
        err_seen++;
      end
    end
  end

  initial begin
    int n;
    int prev_done;
    rst = 1'b1; req = '0; load_val = '0; tc_kill = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    // Single request, v=5 on requester 1.
    set_vals(0, 5, 0, 0);
    single_run(4'b0010);
    @(negedge clk); #1;
    check_eq("busy_after_done", busy, 0);

    // Fairness with all requests held and v=7 everywhere.
    set_vals(7, 7, 7, 7);
    for (int i = 0; i < 5; i++) expect_grant(4'b1111);
    req = 4'b1111;
    wait_ld(ld_seen + 1);
    b2b = 1'b1;
    wait_done(done_seen + 5);
    req = '0;
    b2b = 1'b0;
    @(negedge clk); #1;

    // Boundary start values.
    set_vals(0, 0, 0, 7);
    single_run(4'b1000);
    set_vals(0, 0, 0, 0);
    single_run(4'b0001);

    // Request drop and value change after capture.
    set_vals(0, 0, 2, 0);
    expect_grant(4'b0100);
    req = 4'b0100;
    wait_ld(ld_seen + 1);
    req = '0;
    set_vals(5, 5, 6, 5);
    wait_done(done_seen + 1);

    // Reset in the middle of RUN.
    set_vals(0, 1, 0, 0);
    expect_grant(4'b0010);
    req = 4'b0010;
    wait_ld(ld_seen + 1);
    req = '0;
    n = 0;
    while (!(cnt_en && count_out == 3'd3) && n < 20) begin @(negedge clk); #1; n++; end
    check_eq("reached_count3", count_out, 3);
    prev_done = done_seen;
    rst = 1'b1;
    @(negedge clk); #1;
    check_idle_outputs("midrun_reset");
    q_done.delete();
    rst = 1'b0;
    ptr_m = 0;
    repeat (10) @(negedge clk);
    #1 check_eq("no_done_after_reset", done_seen, prev_done);
    set_vals(3, 0, 0, 6);
    single_run(4'b1001);
    single_run(4'b1000);

`ifdef COUNTER_SCHED_WDOG_EN
    // Watchdog: tc never rises, the run must abort after 9 RUN cycles.
    tc_kill = 1'b1;
    set_vals(0, 7, 7, 7);
    prev_done = done_seen;
    expect_grant(4'b0001);
    req = 4'b0001;
    wait_ld(ld_seen + 1);
    req = '0;
    n = 0;
    while (err_seen < 1 && n < 30) begin @(negedge clk); #1; n++; end
    check_eq("wdog_err_count", err_seen, 1);
    check_eq("wdog_no_done", done_seen, prev_done);
    tc_kill = 1'b0;
    single_run(4'b1111);
`else
    check_eq("err_quiet", err_seen, 0);
`endif

    repeat (3) @(negedge clk);
    #1 check_eq("pending_expectations", q_grant.size() + q_done.size() + q_err.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
